huffman_xmem_loader: RTL



---
 rtl/huffman_xmem_loader.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/huffman_xmem_loader.sv
// Prefix-code decoder and word packer feeding the input SRAM write port.
// One code bit per cycle; col decoded bw-bit symbols make one SRAM word.
module huffman_xmem_loader #(
    parameter int bw     = 4,
    parameter int col    = 8,
    parameter int addr_w = 11
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [addr_w-1:0]   base_addr,
    input  logic [addr_w:0]     num_words,
    input  logic                in_valid,
    input  logic                in_bit,
    output logic                in_ready,
    output logic [bw*col-1:0]   D_xmem,
    output logic                CEN_xmem,
    output logic                WEN_xmem,
    output logic [addr_w-1:0]   A_xmem,
    output logic                busy,
    output logic                done
);

    localparam int idx_w = $clog2(col);
    localparam logic [idx_w-1:0] last_idx = idx_w'(col - 1);
    localparam logic [addr_w:0]  cnt_one  = (addr_w+1)'(1);

    typedef enum logic [2:0] {IDLE, PFX0, PFX1, SUF, WRITE, FIN} state_t;

    state_t              state;
    logic [addr_w-1:0]   base_q;
    logic [addr_w:0]     num_q;
    logic [addr_w:0]     word_cnt;
    logic [idx_w-1:0]    sym_idx;
    logic [bw*col-1:0]   pack;
    logic [2:0]          suf_left;
    logic                suf_long;
    logic [2:0]          suf_sh;

    logic                fire;
    logic                sym_done;
    logic [bw-1:0]       sym_val;
    logic [bw*col-1:0]   word_next;

    // Symbol completion is decoded combinationally from the bit being accepted.
    always_comb begin
        fire      = in_valid && in_ready;
        sym_done  = 1'b0;
        sym_val   = '0;
        if (fire) begin
            if (state == PFX0 && !in_bit) begin
                sym_done = 1'b1;
            end else if (state == SUF && suf_left == 3'd1) begin
                sym_done = 1'b1;
                sym_val  = suf_long ? {suf_sh, in_bit}
                                    : 4'd1 + {2'b00, suf_sh[0], in_bit};
            end
        end
        word_next = pack;
        word_next[bw*sym_idx +: bw] = sym_val;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            base_q   <= '0;
            num_q    <= '0;
            word_cnt <= '0;
            sym_idx  <= '0;
            pack     <= '0;
            suf_left <= '0;
            suf_long <= 1'b0;
            suf_sh   <= '0;
            in_ready <= 1'b0;
            D_xmem   <= '0;
            CEN_xmem <= 1'b1;
            WEN_xmem <= 1'b1;
            A_xmem   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    // busy is still high during the done cycle, so start is ignored there
                    if (start && !busy) begin
                        base_q   <= base_addr;
                        num_q    <= num_words;
                        busy     <= 1'b1;
                        sym_idx  <= '0;
                        word_cnt <= '0;
                        pack     <= '0;
                        if (num_words == '0) begin
                            state <= FIN;
                        end else begin
                            state    <= PFX0;
                            in_ready <= 1'b1;
                        end
                    end
                end
                PFX0, PFX1, SUF: begin
                    if (fire) begin
                        case (state)
                            PFX0: if (in_bit) state <= PFX1;
                            PFX1: begin
                                state    <= SUF;
                                suf_long <= in_bit;
                                suf_left <= in_bit ? 3'd4 : 3'd2;
                            end
                            default: begin
                                suf_sh   <= {suf_sh[1:0], in_bit};
                                suf_left <= suf_left - 3'd1;
                            end
                        endcase
                        if (sym_done) begin
                            if (sym_idx == last_idx) begin
                                state    <= WRITE;
                                in_ready <= 1'b0;
                                CEN_xmem <= 1'b0;
                                WEN_xmem <= 1'b0;
                                A_xmem   <= base_q + word_cnt[addr_w-1:0];
                                D_xmem   <= word_next;
                                pack     <= '0;
                                sym_idx  <= '0;
                            end else begin
                                state   <= PFX0;
                                pack    <= word_next;
                                sym_idx <= sym_idx + idx_w'(1);
                            end
                        end
                    end
                end
                WRITE: begin
                    CEN_xmem <= 1'b1;
                    WEN_xmem <= 1'b1;
                    word_cnt <= word_cnt + cnt_one;
                    if (word_cnt + cnt_one < num_q) begin
                        state    <= PFX0;
                        in_ready <= 1'b1;
                    end else begin
                        state <= FIN;
                    end
                end
                FIN: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
